// File: rtl/io_map_pkg.sv
// Address map shared by the I/O port block: IO space select bit and the
// low-byte register addresses decoded inside that space.
package io_map_pkg;

  localparam int IO_SPACE_BIT = 7;

  localparam logic [7:0] OUT0_ADDR = 8'h80;
  localparam logic [7:0] OUT1_ADDR = 8'h84;
  localparam logic [7:0] OUT2_ADDR = 8'h88;
  localparam logic [7:0] SW0_ADDR  = 8'hC0;
  localparam logic [7:0] SW1_ADDR  = 8'hC4;
  localparam logic [7:0] KEYF_ADDR = 8'hC8;
  localparam logic [7:0] KEYS_ADDR = 8'hCC;

  function automatic logic is_io(input logic [31:0] a);
    return a[IO_SPACE_BIT];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: two-flop synchronizer, stability counter and an
// accepted level, plus a pulse on the cycle the level is accepted as pressed.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic key_stable,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             key_meta;
  logic             key_sync;
  logic [CNT_W-1:0] cnt;

  // Synchronize the raw key and accept a new level only after it held steady.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta   <= 1'b0;
      key_sync   <= 1'b0;
      key_stable <= 1'b0;
      cnt        <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      if (key_sync == key_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key_stable <= key_sync;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // High during the cycle whose closing edge raises key_stable, so the flag
  // can set on that same edge.
  assign rise = ~key_stable & key_sync & (cnt == CNT_MAX);

endmodule

// File: rtl/io_port_unit.sv
// Memory-mapped I/O port block: steers stores to data memory or output
// registers and returns memory data or conditioned board inputs on loads.
module io_port_unit
  import io_map_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int IN_W       = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  input  logic [31:0]     mem_rdata,
  input  logic [IN_W-1:0] sw0,
  input  logic [IN_W-1:0] sw1,
  input  logic            key,
  output logic            dmem_we,
  output logic [31:0]     rdata,
  output logic [31:0]     out_port0,
  output logic [31:0]     out_port1,
  output logic [31:0]     out_port2
);

  logic [IN_W-1:0] sw0_meta;
  logic [IN_W-1:0] sw0_sync;
  logic [IN_W-1:0] sw1_meta;
  logic [IN_W-1:0] sw1_sync;
  logic            key_stable;
  logic            key_rise;
  logic            key_flag;
  logic            io_sel;
  logic [7:0]      reg_addr;
  logic            unused_addr_bits;

  assign io_sel           = is_io(addr);
  assign reg_addr         = addr[7:0];
  assign dmem_we          = we & ~io_sel;
  // Upper address bits are deliberately ignored so the map aliases.
  assign unused_addr_bits = ^addr[31:8];

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .clock      (clock),
    .reset      (reset),
    .key        (key),
    .key_stable (key_stable),
    .rise       (key_rise)
  );

  // Switch synchronizers; switches are levels, so no debounce.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw0_meta <= '0;
      sw0_sync <= '0;
      sw1_meta <= '0;
      sw1_sync <= '0;
    end else begin
      sw0_meta <= sw0;
      sw0_sync <= sw0_meta;
      sw1_meta <= sw1;
      sw1_sync <= sw1_meta;
    end
  end

  // Output port registers written by IO-space stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_port0 <= 32'h0000_0000;
      out_port1 <= 32'h0000_0000;
      out_port2 <= 32'h0000_0000;
    end else if (we && io_sel) begin
      case (reg_addr)
        OUT0_ADDR: out_port0 <= wdata;
        OUT1_ADDR: out_port1 <= wdata;
        OUT2_ADDR: out_port2 <= wdata;
        default: begin
        end
      endcase
    end
  end

  // Sticky press flag; a new press beats a simultaneous software clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_flag <= 1'b0;
    end else if (key_rise) begin
      key_flag <= 1'b1;
    end else if (we && io_sel && (reg_addr == KEYF_ADDR) && wdata[0]) begin
      key_flag <= 1'b0;
    end
  end

  // Load data mux.
  always_comb begin
    rdata = 32'h0000_0000;
    if (!io_sel) begin
      rdata = mem_rdata;
    end else begin
      case (reg_addr)
        SW0_ADDR:  rdata = {{(32-IN_W){1'b0}}, sw0_sync};
        SW1_ADDR:  rdata = {{(32-IN_W){1'b0}}, sw1_sync};
        KEYF_ADDR: rdata = {31'h0000_0000, key_flag};
        KEYS_ADDR: rdata = {31'h0000_0000, key_stable};
        default:   rdata = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: doc/io_port_unit.md
# io_port_unit

Memory-mapped I/O port block in the single-cycle CPU, directly downstream of the ALU. It takes the ALU result as the data address and decodes it. It steers stores either to data memory or to three output port registers, and returns either memory read data or synchronized/debounced board inputs on loads. It owns all I/O-side state: output registers, input synchronizers, key debounce and a sticky key-event flag.

## Interface
Parameters:
- DEB_CYCLES, 4: cycles a synchronized key level must stay stable before it is accepted (≥2; boards use ~500000).
- IN_W, 8: width of each switch input port.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- addr  in  32  ALU result (effective address).
- wdata  in  32  store data (rt).
- we  in  1  store strobe from control unit.
- mem_rdata  in  32  read data from data memory.
- sw0  in  IN_W  raw switch bank 0 (asynchronous).
- sw1  in  IN_W  raw switch bank 1 (asynchronous).
- key  in  1  raw push-button, active-high, bouncy.
- dmem_we  out  1  write enable to data memory.
- rdata  out  32  load data to writeback mux.
- out_port0  out  32  output register 0.
- out_port1  out  32  output register 1.
- out_port2  out  32  output register 2 (LEDs).

## Operation
- IO space: addr[7]=1; memory space: addr[7]=0. addr[31:8] ignored (aliases intended).
- dmem_we = we & ~addr[7]. IO stores never reach memory.
- Write map (we=1, IO space): 0x80 → out_port0, 0x84 → out_port1, 0x88 → out_port2, 0xC8 with wdata[0]=1 → clear key_flag. Any other IO address: write ignored.
- Read map (combinational): memory space → mem_rdata. 0xC0 → zero-extended sw0_sync. 0xC4 → zero-extended sw1_sync. 0xC8 → {31'b0, key_flag}. 0xCC → {31'b0, key_stable}. Other IO addresses → 0.
- Switches: two-flop synchronizer per bit, no debounce.
- Key path: two-flop synchronizer → key_sync. Debounce holds key_stable and cnt (width clog2(DEB_CYCLES)).
  - If key_sync == key_stable: cnt ← 0.
  - Else if cnt == DEB_CYCLES−1: key_stable ← key_sync, cnt ← 0.
  - Else: cnt ← cnt+1.
- Any mismatch-free cycle restarts the count, so glitches shorter than DEB_CYCLES are rejected.
- key_flag is set on the edge where key_stable goes 0→1. It stays set until cleared by the 0xC8 write.
- Simultaneous set and clear: set wins.
- Release (1→0) never sets the flag.

## Timing
- Reset values: out_port0/1/2 = 0, sync flops = 0, key_stable = 0, cnt = 0, key_flag = 0. Therefore rdata = mem_rdata or 0 per map, and dmem_we follows we combinationally.
- Output register write: value visible on out_port* immediately after the edge on which we=1. Back-to-back writes to the same port: last wins each cycle.
- Switch latency: a raw change is readable after the 2nd rising edge.
- Key latency: a clean press at cycle 0 gives key_sync=1 after edge 2. key_stable and key_flag become 1 after edge 2+DEB_CYCLES (edge 6 at default).
- Reads are combinational. A load of 0xC8 in the same cycle as a clearing store is impossible in a single-cycle CPU. A read of 0xC8 in the cycle the flag sets returns the pre-edge value.
- Reset mid-debounce discards progress. A key held through reset re-debounces from zero after reset deasserts and sets key_flag again.

## Structure
- Shared package io_map_pkg: IO_SPACE_BIT (7), address constants OUT0_ADDR 8'h80, OUT1_ADDR 8'h84, OUT2_ADDR 8'h88, SW0_ADDR 8'hC0, SW1_ADDR 8'hC4, KEYF_ADDR 8'hC8, KEYS_ADDR 8'hCC.
- One sub-module: key_debounce (synchronizer, counter, key_stable, rise pulse output). Flag, decode and muxing stay in io_port_unit.

## Test plan
- Reset then we=1, addr=0x00000084, wdata=0xDEADBEEF → out_port1=0xDEADBEEF next cycle; dmem_we=0; out_port0/2 stay 0.
- we=1, addr=0x00000010 → dmem_we=1, no out_port change. Read addr=0x10 with mem_rdata=0x12345678 → rdata=0x12345678.
- sw0=8'hA5 applied at cycle 0 → rdata at addr 0xC0 is 0 before edge 2 and 0x000000A5 after it. addr 0xD0 → 0.
- key high from cycle 0 (DEB_CYCLES=4) → 0xC8 reads 0 through edge 5 and 1 after edge 6. Store 0xC8 with wdata=1 → reads 0. Release → stays 0.
- key pulses high 3 cycles then low, repeated 5 times → key_stable and key_flag never set.
- key held, reset asserted for 2 cycles after key_flag set → flag 0 during reset, set again 2+DEB_CYCLES edges after reset deasserts. Clear and set on the same edge → flag remains 1.
